// File: rtl/op_result_pipe_if.sv
// Operation/result handshake bundle between the arithmetic stage,
// the result buffer and the downstream consumer.
interface op_result_pipe_if #(
    parameter int NBIT = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [NBIT-1:0] b;
    logic [NBIT:0]   sum;
    logic [NBIT:0]   sub;
    logic [NBIT:0]   multi;
    logic [NBIT:0]   div;
    logic [NBIT:0]   mod;
    logic [NBIT:0]   square;
    logic            out_valid;
    logic            out_ready;
    logic [NBIT:0]   out_data;
    logic [2:0]      out_op;
    logic            out_err;

    modport master (
        output in_valid, op, b,
        output sum, sub, multi, div, mod, square,
        output out_ready,
        input  in_ready, out_valid,
        input  out_data, out_op, out_err
    );

    modport slave (
        input  in_valid, op, b,
        input  sum, sub, multi, div, mod, square,
        input  out_ready,
        output in_ready, out_valid,
        output out_data, out_op, out_err
    );
endinterface

// File: rtl/op_result_pipe.sv
// Two-entry result buffer: selects the arithmetic result for the issued
// op, flags illegal ops and divide-by-zero, and counts retired results.
module op_result_pipe #(
    parameter int NBIT  = 4,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rstn,
    op_result_pipe_if.slave   io,
    output logic [7:0]        done_cnt,
    output logic [7:0]        err_cnt
);
    localparam int W = NBIT + 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e             state_q;
    occ_e             state_d;
    logic             wptr_q;
    logic             rptr_q;
    logic [W-1:0]     data_mem [DEPTH];
    logic [2:0]       op_mem   [DEPTH];
    logic [DEPTH-1:0] err_mem;
    logic             push;
    logic             pop;
    logic             bzero;
    logic [W-1:0]     cap_data;
    logic             cap_err;

    // Handshake flags come from the occupancy register only.
    assign io.in_ready  = (state_q != FULL);
    assign io.out_valid = (state_q != EMPTY);

    assign push = io.in_valid & io.in_ready;
    assign pop  = io.out_valid & io.out_ready;

    // Empty slots are masked so stale entries never leak out.
    assign io.out_data = io.out_valid ? data_mem[rptr_q] : '0;
    assign io.out_op   = io.out_valid ? op_mem[rptr_q] : 3'd0;
    assign io.out_err  = io.out_valid & err_mem[rptr_q];

    assign bzero = (io.b == '0);

    always_comb begin
        cap_data = '0;
        cap_err  = 1'b0;
        unique case (1'b1)
            (io.op == 3'd0): cap_data = io.sum;
            (io.op == 3'd1): cap_data = io.sub;
            (io.op == 3'd2): cap_data = io.multi;
            (io.op == 3'd5): cap_data = io.square;
            (io.op == 3'd3 && !bzero): cap_data = io.div;
            (io.op == 3'd4 && !bzero): cap_data = io.mod;
            ((io.op == 3'd3 || io.op == 3'd4) && bzero): begin
                cap_data = '1;
                cap_err  = 1'b1;
            end
            default: begin
                cap_data = '0;
                cap_err  = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop) state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL: if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= EMPTY;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            done_cnt <= 8'd0;
            err_cnt  <= 8'd0;
        end else begin
            state_q <= state_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) begin
                rptr_q   <= rptr_q + 1'b1;
                done_cnt <= done_cnt + 8'd1;
                if (io.out_err) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && push) begin
            data_mem[wptr_q] <= cap_data;
            op_mem[wptr_q]   <= io.op;
            err_mem[wptr_q]  <= cap_err;
        end
    end
endmodule

// File: tb/tb_op_result_pipe.sv
// Scoreboard bench for op_result_pipe: random and directed traffic
// against a behavioural model of the result selection and buffering.
module tb_op_result_pipe;
    localparam int NBIT = 4;
    localparam int W    = NBIT + 1;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] done_cnt;
    logic [7:0] err_cnt;

    op_result_pipe_if #(.NBIT(NBIT)) bus ();

    op_result_pipe #(.NBIT(NBIT), .DEPTH(2)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .io       (bus),
        .done_cnt (done_cnt),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] data;
        logic [2:0]   op;
        logic         err;
    } exp_t;

    exp_t            sb[$];
    exp_t            mon_e;
    int              checks = 0;
    int              errors = 0;
    int              occ    = 0;
    logic [7:0]      exp_done = 8'd0;
    logic [7:0]      exp_err  = 8'd0;
    logic [2:0]      cur_op = 3'd0;
    logic [NBIT-1:0] cur_a  = '0;
    logic [NBIT-1:0] cur_b  = '0;
    bit              rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op,
                                   input logic [NBIT-1:0] a,
                                   input logic [NBIT-1:0] b);
        exp_t        e;
        int unsigned ia = a;
        int unsigned ib = b;
        int unsigned r  = 0;
        e.op  = op;
        e.err = 1'b0;
        case (op)
            3'd0: r = ia + ib;
            3'd1: r = ia - ib;
            3'd2: r = ia * ib;
            3'd3: if (ib == 0) begin
                r = (1 << W) - 1; e.err = 1'b1;
            end else r = ia / ib;
            3'd4: if (ib == 0) begin
                r = (1 << W) - 1; e.err = 1'b1;
            end else r = ia % ib;
            3'd5: r = ia * ia;
            default: begin
                r = 0; e.err = 1'b1;
            end
        endcase
        e.data = W'(r % (1 << W));
        return e;
    endfunction

    task automatic drive(input logic [2:0] op,
                         input logic [NBIT-1:0] a,
                         input logic [NBIT-1:0] b);
        cur_op = op;
        cur_a  = a;
        cur_b  = b;
        bus.op     = op;
        bus.b      = b;
        bus.sum    = W'(a) + W'(b);
        bus.sub    = W'(a) - W'(b);
        bus.multi  = W'(a) * W'(b);
        bus.square = W'(a) * W'(a);
        bus.div    = (b == '0) ? W'(7) : W'(a / b);
        bus.mod    = (b == '0) ? W'(a) : W'(a % b);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the operation until accepted, as an upstream stage must.
    task automatic send(input logic [2:0] op,
                        input logic [NBIT-1:0] a,
                        input logic [NBIT-1:0] b);
        int n = 0;
        bit acc = 1'b0;
        drive(op, a, b);
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (occ != 0 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("drain_occ", 32'(occ), 32'd0);
    endtask

    // Flow-control checker and expected-result producer.
    always @(negedge clk) begin
        if (rstn) begin
            chk("in_ready", 32'(bus.in_ready), 32'(occ < 2));
            chk("out_valid", 32'(bus.out_valid), 32'(occ > 0));
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model(cur_op, cur_a, cur_b));
                occ++;
            end
            if (bus.out_valid && bus.out_ready) occ--;
        end
    end

    // Monitor: compares the presented head against the scoreboard.
    always @(negedge clk) begin
        if (rstn) begin
            chk("done_cnt", 32'(done_cnt), 32'(exp_done));
            chk("err_cnt", 32'(err_cnt), 32'(exp_err));
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got data %0h expected none",
                             bus.out_data);
                end else begin
                    mon_e = sb[0];
                    chk("out_data", 32'(bus.out_data), 32'(mon_e.data));
                    chk("out_op", 32'(bus.out_op), 32'(mon_e.op));
                    chk("out_err", 32'(bus.out_err), 32'(mon_e.err));
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        exp_done = exp_done + 8'd1;
                        if (mon_e.err) exp_err = exp_err + 8'd1;
                    end
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(3'd0, '0, '0);
        rstn = 1'b0;
        cyc(2);
        rstn = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_op", 32'(bus.out_op), 32'd0);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
        chk("rst_done", 32'(done_cnt), 32'd0);
        @(posedge clk);
        #1;

        // Basic sum with one-cycle latency.
        bus.out_ready = 1'b1;
        send(3'd0, 4'd2, 4'd3);
        chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_out_data", 32'(bus.out_data), 32'd5);
        cyc(1);
        chk("basic_done", 32'(done_cnt), 32'd1);

        send(3'd3, 4'd7, 4'd0);
        cyc(2);
        chk("dz_err_cnt", 32'(err_cnt), 32'd1);
        send(3'd6, 4'd9, 4'd4);
        cyc(2);
        chk("ill_err_cnt", 32'(err_cnt), 32'd2);

        // Back-pressure: fill, offer a third op, then release.
        bus.out_ready = 1'b0;
        send(3'd0, 4'd1, 4'd2);
        send(3'd2, 4'd3, 4'd4);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        drive(3'd0, 4'd5, 4'd5);
        bus.in_valid = 1'b1;
        cyc(3);
        chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc(3);
        chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
        chk("bp_done", 32'(done_cnt), 32'd5);

        // Simultaneous push and pop with one entry resident.
        bus.out_ready = 1'b0;
        send(3'd1, 4'd9, 4'd2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(3'd0, 4'(i), 4'd1);
            chk("pp_valid", 32'(bus.out_valid), 32'd1);
            chk("pp_ready", 32'(bus.in_ready), 32'd1);
        end
        drain();

        // Random traffic with random back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(0, 2));
            send(3'($urandom_range(0, 7)), 4'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom));
        end
        rand_rdy = 1'b0;
        cyc(1);
        bus.out_ready = 1'b1;
        drain();

        // Reset with a full buffer discards everything.
        bus.out_ready = 1'b0;
        send(3'd5, 4'd3, 4'd1);
        send(3'd4, 4'd6, 4'd0);
        chk("rst_full", 32'(bus.in_ready), 32'd0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        sb.delete();
        occ      = 0;
        exp_done = 8'd0;
        exp_err  = 8'd0;
        chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_done", 32'(done_cnt), 32'd0);
        chk("mid_err", 32'(err_cnt), 32'd0);
        chk("mid_out_data", 32'(bus.out_data), 32'd0);
        bus.out_ready = 1'b1;
        cyc(3);
        chk("mid_stale", 32'(bus.out_valid), 32'd0);

        // 256 retirements wrap the done counter back to zero.
        for (int i = 0; i < 256; i++) send(3'd0, 4'(i), 4'(i >> 4));
        drain();
        chk("wrap_done", 32'(done_cnt), 32'd0);
        chk("wrap_err", 32'(err_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/op_result_pipe.md
OP_RESULT_PIPE -- requirements
Module: op_result_pipe

Interface
REQ-001 Parameter: NBIT, default 4, operand width; result width is NBIT+1.
REQ-002 Parameter: DEPTH, fixed 2, number of buffer entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream presents an operation.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 op  input  3  operation select: 0 sum, 1 sub, 2 multi, 3 div, 4 mod, 5 square, 6-7 illegal.
REQ-008 b  input  NBIT  divisor operand, used for divide-by-zero detection.
REQ-009 sum, sub, multi, div, mod, square  input  NBIT+1 each  results from the arithmetic stage for the current operands.
REQ-010 out_valid  output  1  buffer head holds a result.
REQ-011 out_ready  input  1  downstream accepts the head.
REQ-012 out_data  output  NBIT+1  selected result at the head.
REQ-013 out_op  output  3  op code captured with the head entry.
REQ-014 out_err  output  1  error flag captured with the head entry.
REQ-015 done_cnt  output  8  count of results popped.
REQ-016 err_cnt  output  8  count of popped results with out_err=1.

Function
REQ-017 push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-018 in_ready SHALL be 1 when occupancy < 2, from registered state only, with no combinational path from out_ready.
REQ-019 out_valid SHALL be 1 when occupancy > 0; out_data, out_op and out_err SHALL be driven from the head entry.
REQ-020 On push, the captured data SHALL be the input selected by op; err SHALL be 0 for op 0, 1, 2 and 5.
REQ-021 Op 3 or 4 with b == 0: data SHALL be all ones (NBIT+1 bits), err SHALL be 1.
REQ-022 Op 6 or 7: data SHALL be 0, err SHALL be 1.
REQ-023 Latency: an entry pushed in cycle N into an empty buffer SHALL show out_valid=1 in cycle N+1; there is no same-cycle bypass.
REQ-024 Order SHALL be strict FIFO; write and read pointers are 1 bit each and wrap 1 -> 0.
REQ-025 Push and pop in the same cycle SHALL leave occupancy unchanged and SHALL lose no data.
REQ-026 When full, in_ready=0, input is ignored, and upstream holds its values.
REQ-027 While out_valid=1 and out_ready=0, the head entry SHALL remain stable.
REQ-028 done_cnt SHALL increment by 1 on each pop and wrap from 255 to 0.
REQ-029 err_cnt SHALL increment by 1 on each pop with out_err=1 and wrap from 255 to 0.
REQ-030 State encoding: occupancy has three states, EMPTY(0), ONE(1), FULL(2).
  - EMPTY -> ONE on push.
  - ONE -> FULL on push without pop.
  - ONE -> EMPTY on pop without push.
  - FULL -> ONE on pop.
  - All other combinations hold the current state.

Reset
REQ-031 When rstn=0 at a rising edge:
  - occupancy -> EMPTY; both pointers -> 0.
  - done_cnt and err_cnt -> 0.
  - out_valid=0, in_ready=1, out_data=0, out_op=0, out_err=0 from the next cycle.
REQ-032 Reset during traffic SHALL discard all buffered entries.
REQ-033 No push or pop SHALL occur in any cycle where rstn=0.

Verification
REQ-034 Basic sum: NBIT=4, op=0, sum=5'd5, in_valid=1 for one cycle, out_ready=1 -> next cycle out_valid=1, out_data=5, out_err=0; done_cnt becomes 1.
REQ-035 Divide by zero: op=3, b=0, div=5'd7 -> out_data=5'b11111, out_err=1; after pop, err_cnt=1. Repeat with op=6 -> out_data=0, out_err=1.
REQ-036 Back-pressure: out_ready=0, push ops 0 then 2 (sum=3, multi=12) -> in_ready=0 after the second push; a third in_valid is not accepted. Raise out_ready -> outputs 3 then 12 in order; in_ready returns to 1.
REQ-037 Simultaneous push/pop: with one entry held, assert in_valid and out_ready together for 10 cycles using distinct values -> occupancy stays ONE and all 10 values appear in order.
REQ-038 Reset mid-operation: FULL buffer, rstn=0 for one cycle -> out_valid=0, in_ready=1, done_cnt=0, err_cnt=0; stale data is never presented.
REQ-039 Counter wrap: 256 pops -> done_cnt returns to 0.
